// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: default address width,
// opcodes recognised by the optional predecode, FSM state encoding.
package instruction_fetch_unit_pkg;

    // Default instruction memory word-address width
    localparam int unsigned IfuAddrW = 6;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StFetch = 2'b01,
        StDone  = 2'b10
    } ifu_state_e;

    typedef struct packed {
        logic is_rtype;
        logic is_lw;
    } predecode_t;

    // Classify a primary opcode for the decode-side hints
    function automatic predecode_t predecode(input logic [5:0] opcode);
        predecode_t p;
        p.is_rtype = (opcode == OpRtype);
        p.is_lw    = (opcode == OpLw);
        return p;
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_pc_counter.sv
// Fetch PC counter: program counter register with asynchronous reset,
// increment enable and parallel load. Load (redirect) beats increment.
module instruction_fetch_unit_pc_counter #(
    parameter int unsigned ADDR_W   = 6,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_pc_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] pc_o
);

    localparam logic [ADDR_W-1:0] ResetPc = ADDR_W'(RESET_PC);

    logic [ADDR_W-1:0] pc_d, pc_q;

    // Next PC: redirect target, sequential successor (wraps), or hold
    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_pc_i;
        end else if (inc_i) begin
            pc_d = pc_q + ADDR_W'(1);
        end
    end

    // PC register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q <= ResetPc;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, addresses the combinational instruction
// memory and holds the fetched word in a registered IF/ID valid/ready stage.
// Supports start/done program sequencing and redirect with flush.
// Optional feature macro: IFU_PREDECODE_EN adds registered if_is_rtype_o /
// if_is_lw_o hints that travel with if_instr_o.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int unsigned ADDR_W   = IfuAddrW,
    parameter int unsigned RESET_PC = 0,
    parameter int unsigned PROG_LEN = 10
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic [31:0]       imem_data_i,
    input  logic              redirect_valid_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    input  logic              id_ready_i,
    output logic              if_valid_o,
    output logic [31:0]       if_instr_o,
    output logic [ADDR_W-1:0] if_pc_o,
`ifdef IFU_PREDECODE_EN
    output logic              if_is_rtype_o,
    output logic              if_is_lw_o,
`endif
    output logic              done_o
);

    localparam logic [ADDR_W-1:0] LastPc = ADDR_W'(PROG_LEN - 1);

    ifu_state_e        state_d, state_q;
    logic [ADDR_W-1:0] pc;
    logic              load;
    logic              done;

    logic              if_valid_d, if_valid_q;
    logic [31:0]       if_instr_d, if_instr_q;
    logic [ADDR_W-1:0] if_pc_d, if_pc_q;

    // PC: redirect loads in any state, every accepted fetch advances it
    instruction_fetch_unit_pc_counter #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_counter (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .load_i    (redirect_valid_i),
        .load_pc_i (redirect_pc_i),
        .inc_i     (load),
        .pc_o      (pc)
    );

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; a redirect in IDLE only moves the PC
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start_i && !redirect_valid_i) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                if (load && (pc == LastPc)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (redirect_valid_i) begin
                    state_d = StFetch;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs: fetch when the IF/ID slot is free or draining, unless flushing
    always_comb begin
        load = (state_q == StFetch) && (!if_valid_q || id_ready_i) && !redirect_valid_i;
        done = (state_q == StDone);
    end

    // IF/ID next state: flush wins, then load, then drain on acceptance
    always_comb begin
        if_valid_d = if_valid_q;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;
        if (redirect_valid_i) begin
            if_valid_d = 1'b0;
        end else if (load) begin
            if_valid_d = 1'b1;
            if_instr_d = imem_data_i;
            if_pc_d    = pc;
        end else if (id_ready_i && if_valid_q) begin
            if_valid_d = 1'b0;
        end
    end

    // IF/ID pipeline register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            if_valid_q <= 1'b0;
            if_instr_q <= '0;
            if_pc_q    <= '0;
        end else begin
            if_valid_q <= if_valid_d;
            if_instr_q <= if_instr_d;
            if_pc_q    <= if_pc_d;
        end
    end

`ifdef IFU_PREDECODE_EN
    predecode_t pd_d, pd_q;

    // Predecode hints follow if_instr: recomputed only when a word is loaded
    always_comb begin
        pd_d = pd_q;
        if (load && !redirect_valid_i) begin
            pd_d = predecode(imem_data_i[31:26]);
        end
    end

    // Predecode register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pd_q <= '0;
        end else begin
            pd_q <= pd_d;
        end
    end

    assign if_is_rtype_o = pd_q.is_rtype;
    assign if_is_lw_o    = pd_q.is_lw;
`endif

    assign imem_addr_o = pc;
    assign if_valid_o  = if_valid_q;
    assign if_instr_o  = if_instr_q;
    assign if_pc_o     = if_pc_q;
    assign done_o      = done;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed self-checking bench for instruction_fetch_unit.
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_instruction_fetch_unit;

    localparam int unsigned ADDR_W   = 6;
    localparam int unsigned PROG_LEN = 10;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_data;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              id_ready;
    logic              if_valid;
    logic [31:0]       if_instr;
    logic [ADDR_W-1:0] if_pc;
    logic              done;
`ifdef IFU_PREDECODE_EN
    logic              if_is_rtype;
    logic              if_is_lw;
`endif

    logic [31:0] mem [64];
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr];

    instruction_fetch_unit #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (0),
        .PROG_LEN (PROG_LEN)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .start_i          (start),
        .imem_addr_o      (imem_addr),
        .imem_data_i      (imem_data),
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redirect_pc),
        .id_ready_i       (id_ready),
        .if_valid_o       (if_valid),
        .if_instr_o       (if_instr),
        .if_pc_o          (if_pc),
`ifdef IFU_PREDECODE_EN
        .if_is_rtype_o    (if_is_rtype),
        .if_is_lw_o       (if_is_lw),
`endif
        .done_o           (done)
    );

    // Program image: words 0-8 R-type (add), word 9 lw, everything else addi
    function automatic logic [31:0] word_at(input int a);
        if (a == 9) return {6'b100011, 5'd1, 5'd2, 16'h0040};
        if (a < 9) return {6'b000000, 5'(a), 5'(a + 1), 5'(a + 2), 5'd0, 6'h20};
        return {6'b001000, 26'(a * 3 + 1)};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({if_valid, if_pc, if_instr, done, imem_addr} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs got v=%0b pc=%0d instr=%h done=%0b addr=%0d want all 0",
                     if_valid, if_pc, if_instr, done, imem_addr);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({if_valid, done, imem_addr} !== '0) begin
            n_err++;
            $display("FAIL idle_after_reset got v=%0b done=%0b addr=%0d want 0/0/0",
                     if_valid, done, imem_addr);
        end
    endtask

    task automatic test_stream();
        start = 1'b1; id_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_vec++;
        if (if_valid !== 1'b0 || imem_addr !== 6'd0) begin
            n_err++;
            $display("FAIL stream_start got v=%0b addr=%0d want v=0 addr=0", if_valid, imem_addr);
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_vec++;
            if ({if_valid, if_pc, if_instr, done} !== {1'b1, 6'(k), word_at(k), (k == 9)}) begin
                n_err++;
                $display("FAIL stream_word%0d got v=%0b pc=%0d instr=%h done=%0b want 1/%0d/%h/%0b",
                         k, if_valid, if_pc, if_instr, done, k, word_at(k), (k == 9));
            end
`ifdef IFU_PREDECODE_EN
            n_vec++;
            if ({if_is_rtype, if_is_lw} !== {(k != 9), (k == 9)}) begin
                n_err++;
                $display("FAIL predecode_word%0d got rtype=%0b lw=%0b want %0b/%0b",
                         k, if_is_rtype, if_is_lw, (k != 9), (k == 9));
            end
`endif
        end
        @(negedge clk);
        n_vec++;
        if ({if_valid, done, imem_addr} !== {1'b0, 1'b1, 6'd10}) begin
            n_err++;
            $display("FAIL done_drain got v=%0b done=%0b addr=%0d want 0/1/10",
                     if_valid, done, imem_addr);
        end
        // start outside IDLE has no effect
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_vec++;
        if ({if_valid, done, imem_addr} !== {1'b0, 1'b1, 6'd10}) begin
            n_err++;
            $display("FAIL start_in_done got v=%0b done=%0b addr=%0d want 0/1/10",
                     if_valid, done, imem_addr);
        end
    endtask

    task automatic test_stall();
        redirect_valid = 1'b1; redirect_pc = 6'd0; id_ready = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b0;
        n_vec++;
        if ({if_valid, done, imem_addr} !== {1'b0, 1'b0, 6'd0}) begin
            n_err++;
            $display("FAIL redirect_from_done got v=%0b done=%0b addr=%0d want 0/0/0",
                     if_valid, done, imem_addr);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_vec++;
            if ({if_valid, if_pc, if_instr} !== {1'b1, 6'(k), word_at(k)}) begin
                n_err++;
                $display("FAIL restream_word%0d got v=%0b pc=%0d instr=%h want 1/%0d/%h",
                         k, if_valid, if_pc, if_instr, k, word_at(k));
            end
        end
        id_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            n_vec++;
            if ({if_valid, if_pc, if_instr, imem_addr} !== {1'b1, 6'd4, word_at(4), 6'd5}) begin
                n_err++;
                $display("FAIL stall_cycle%0d got v=%0b pc=%0d instr=%h addr=%0d want 1/4/%h/5",
                         s, if_valid, if_pc, if_instr, imem_addr, word_at(4));
            end
        end
        id_ready = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({if_valid, if_pc, if_instr} !== {1'b1, 6'd5, word_at(5)}) begin
            n_err++;
            $display("FAIL stall_resume got v=%0b pc=%0d instr=%h want 1/5/%h",
                     if_valid, if_pc, if_instr, word_at(5));
        end
    endtask

    task automatic test_redirect();
        @(negedge clk);
        n_vec++;
        if ({if_valid, if_pc} !== {1'b1, 6'd6}) begin
            n_err++;
            $display("FAIL pre_redirect got v=%0b pc=%0d want 1/6", if_valid, if_pc);
        end
        redirect_valid = 1'b1; redirect_pc = 6'd2;
        @(negedge clk);
        redirect_valid = 1'b0;
        n_vec++;
        if ({if_valid, imem_addr} !== {1'b0, 6'd2}) begin
            n_err++;
            $display("FAIL redirect_flush got v=%0b addr=%0d want 0/2", if_valid, imem_addr);
        end
        for (int k = 2; k < 4; k++) begin
            @(negedge clk);
            n_vec++;
            if ({if_valid, if_pc, if_instr} !== {1'b1, 6'(k), word_at(k)}) begin
                n_err++;
                $display("FAIL redirect_word%0d got v=%0b pc=%0d instr=%h want 1/%0d/%h",
                         k, if_valid, if_pc, if_instr, k, word_at(k));
            end
        end
    endtask

    task automatic test_redirect_vs_ready();
        // id_ready is high here, so word 4 would be loaded without the redirect
        redirect_valid = 1'b1; redirect_pc = 6'd8;
        @(negedge clk);
        redirect_valid = 1'b0;
        n_vec++;
        if ({if_valid, imem_addr} !== {1'b0, 6'd8}) begin
            n_err++;
            $display("FAIL race_flush got v=%0b pc=%0d addr=%0d want v=0 addr=8",
                     if_valid, if_pc, imem_addr);
        end
        for (int k = 8; k < 10; k++) begin
            @(negedge clk);
            n_vec++;
            if ({if_valid, if_pc, if_instr, done} !== {1'b1, 6'(k), word_at(k), (k == 9)}) begin
                n_err++;
                $display("FAIL race_word%0d got v=%0b pc=%0d instr=%h done=%0b want 1/%0d/%h/%0b",
                         k, if_valid, if_pc, if_instr, done, k, word_at(k), (k == 9));
            end
        end
    endtask

    task automatic test_reset_mid();
        redirect_valid = 1'b1; redirect_pc = 6'd0;
        @(negedge clk);
        redirect_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            n_vec++;
            if ({if_valid, if_pc} !== {1'b1, 6'(k)}) begin
                n_err++;
                $display("FAIL mid_word%0d got v=%0b pc=%0d want 1/%0d", k, if_valid, if_pc, k);
            end
        end
        // Assert reset between clock edges: outputs must clear without an edge
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({if_valid, if_pc, if_instr, done, imem_addr} !== '0) begin
            n_err++;
            $display("FAIL async_reset got v=%0b pc=%0d instr=%h done=%0b addr=%0d want all 0",
                     if_valid, if_pc, if_instr, done, imem_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({if_valid, imem_addr} !== {1'b0, 6'd0}) begin
            n_err++;
            $display("FAIL post_reset_idle got v=%0b addr=%0d want 0/0", if_valid, imem_addr);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_vec++;
            if ({if_valid, if_pc, if_instr} !== {1'b1, 6'(k), word_at(k)}) begin
                n_err++;
                $display("FAIL restart_word%0d got v=%0b pc=%0d instr=%h want 1/%0d/%h",
                         k, if_valid, if_pc, if_instr, k, word_at(k));
            end
        end
    endtask

    initial begin
        for (int a = 0; a < 64; a++) mem[a] = word_at(a);
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_redirect_vs_ready();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
